// File: rtl/fault_sram_pkg.sv
// Shared constants, fault type codes and helpers for the fault-injecting SRAM model.
package fault_sram_pkg;

  localparam int DEF_WORD_WIDTH = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_NUM_FAULTS = 4;
  localparam int CLK_PERIOD     = 10;

  // Codes 6 and 7 are never stored; they are mapped to FT_NONE on load.
  typedef enum logic [2:0] {
    FT_NONE  = 3'd0,
    FT_SA0   = 3'd1,
    FT_SA1   = 3'd2,
    FT_TF_UP = 3'd3,
    FT_TF_DN = 3'd4,
    FT_CFIN  = 3'd5
  } fault_e;

  // Index width that never collapses to zero bits for single-entry tables or 1-bit words.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Fold unknown codes into NONE so the rest of the design only sees legal types.
  function automatic fault_e decode_type(input logic [2:0] code);
    return (code > 3'd5) ? FT_NONE : fault_e'(code);
  endfunction

endpackage

// File: rtl/fault_entry.sv
// One fault-table slot: holds its configuration and, for the current access address,
// reports which bit it claims (cell_mask), whether it forces a value, keeps the old value,
// or marks this address as a coupling-fault aggressor (cfin_mask).
module fault_entry
  import fault_sram_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_WIDTH,
  parameter int ADDR_W = DEF_ADDR_WIDTH,
  parameter int BIT_W  = idx_width(DEF_WORD_WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [2:0]        cfg_type,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [ADDR_W-1:0] cfg_aggr_addr,
  input  logic [BIT_W-1:0]  cfg_bit,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [WORD_W-1:0] old_word,
  output logic [WORD_W-1:0] cell_mask,
  output logic [WORD_W-1:0] force_mask,
  output logic [WORD_W-1:0] force_val,
  output logic [WORD_W-1:0] keep_mask,
  output logic [WORD_W-1:0] cfin_mask,
  output logic [ADDR_W-1:0] victim_addr
);

  fault_e              type_q, type_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   aggr_q, aggr_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [WORD_W-1:0]   bit_oh;

  // Next-state for the slot: overwrite everything on an accepted config, otherwise hold.
  always_comb begin
    type_d = type_q;
    addr_d = addr_q;
    aggr_d = aggr_q;
    bit_d  = bit_q;
    if (load) begin
      type_d = decode_type(cfg_type);
      addr_d = cfg_addr;
      aggr_d = cfg_aggr_addr;
      bit_d  = cfg_bit;
    end
  end

  // Slot registers; reset leaves the slot inert.
  always_ff @(posedge clk) begin
    if (!rst) begin
      type_q <= FT_NONE;
      addr_q <= '0;
      aggr_q <= '0;
      bit_q  <= '0;
    end else begin
      type_q <= type_d;
      addr_q <= addr_d;
      aggr_q <= aggr_d;
      bit_q  <= bit_d;
    end
  end

  // Per-access masks for the address currently on the bus.
  always_comb begin
    bit_oh     = WORD_W'(1) << bit_q;
    cell_mask  = '0;
    force_mask = '0;
    force_val  = '0;
    keep_mask  = '0;
    cfin_mask  = '0;
    if (addr_q == acc_addr) begin
      case (type_q)
        FT_SA0: begin
          cell_mask  = bit_oh;
          force_mask = bit_oh;
        end
        FT_SA1: begin
          cell_mask  = bit_oh;
          force_mask = bit_oh;
          force_val  = bit_oh;
        end
        FT_TF_UP: begin
          cell_mask = bit_oh;
          keep_mask = bit_oh & ~old_word;
        end
        FT_TF_DN: begin
          cell_mask = bit_oh;
          keep_mask = bit_oh & old_word;
        end
        default: ;
      endcase
    end
    // A coupling fault whose victim is its own aggressor is meaningless and is ignored.
    if ((type_q == FT_CFIN) && (aggr_q == acc_addr) && (aggr_q != addr_q)) begin
      cfin_mask = bit_oh;
    end
    victim_addr = addr_q;
  end

endmodule

// File: rtl/fault_sram.sv
// Register-array SRAM with a programmable fault table, used as the memory under test
// for BIST controllers. A shadow array tracks fault-free contents so fault_hit can
// report any access whose stored or returned word deviates from ideal behaviour.
module fault_sram
  import fault_sram_pkg::*;
#(
  parameter int SRAM_WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int SRAM_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_FAULTS      = DEF_NUM_FAULTS,
  localparam int IDX_W = idx_width(NUM_FAULTS),
  localparam int BIT_W = idx_width(SRAM_WORD_WIDTH),
  localparam int DEPTH = 1 << SRAM_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [SRAM_ADDR_WIDTH-1:0] data_addr,
  input  logic [SRAM_WORD_WIDTH-1:0] data_in,
  output logic [SRAM_WORD_WIDTH-1:0] data_out,
  output logic                       fault_hit,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [IDX_W-1:0]           cfg_idx,
  input  logic [2:0]                 cfg_type,
  input  logic [SRAM_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [SRAM_ADDR_WIDTH-1:0] cfg_aggr_addr,
  input  logic [BIT_W-1:0]           cfg_bit
);

  localparam int W = SRAM_WORD_WIDTH;
  localparam int A = SRAM_ADDR_WIDTH;

  logic [W-1:0] mem_q  [DEPTH];
  logic [W-1:0] mem_d  [DEPTH];
  logic [W-1:0] gold_q [DEPTH];
  logic [W-1:0] gold_d [DEPTH];

  logic [W-1:0] data_out_q, data_out_d;
  logic         fault_hit_q, fault_hit_d;
  logic         cfg_ready_q, cfg_ready_d;

  logic                  cfg_accept;
  logic [NUM_FAULTS-1:0] load;

  logic [W-1:0] cell_mask   [NUM_FAULTS];
  logic [W-1:0] force_mask  [NUM_FAULTS];
  logic [W-1:0] force_val   [NUM_FAULTS];
  logic [W-1:0] keep_mask   [NUM_FAULTS];
  logic [W-1:0] cfin_mask   [NUM_FAULTS];
  logic [A-1:0] victim_addr [NUM_FAULTS];

  logic [W-1:0] old_word;
  logic [W-1:0] wr_word;
  logic [W-1:0] rd_word;
  logic [W-1:0] flip;
  logic [W-1:0] fire;
  logic         cfin_any;

  assign cfg_accept = cfg_valid && cfg_ready_q;
  assign old_word   = mem_q[data_addr];
  assign flip       = old_word ^ wr_word;

  // Route an accepted config to the selected slot; the slot sees it on the next edge,
  // so an access in the same cycle still uses the old table.
  always_comb begin
    for (int i = 0; i < NUM_FAULTS; i++) begin
      load[i] = cfg_accept && (cfg_idx == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_FAULTS; g++) begin : g_entry
    fault_entry #(
      .WORD_W (W),
      .ADDR_W (A),
      .BIT_W  (BIT_W)
    ) u_entry (
      .clk           (clk),
      .rst           (rst),
      .load          (load[g]),
      .cfg_type      (cfg_type),
      .cfg_addr      (cfg_addr),
      .cfg_aggr_addr (cfg_aggr_addr),
      .cfg_bit       (cfg_bit),
      .acc_addr      (data_addr),
      .old_word      (old_word),
      .cell_mask     (cell_mask[g]),
      .force_mask    (force_mask[g]),
      .force_val     (force_val[g]),
      .keep_mask     (keep_mask[g]),
      .cfin_mask     (cfin_mask[g]),
      .victim_addr   (victim_addr[g])
    );
  end

  // Priority reduction: walk from the highest slot down so the lowest index lands last and wins.
  always_comb begin
    wr_word = data_in;
    rd_word = old_word;
    for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
      wr_word = (wr_word & ~cell_mask[i])
              | (cell_mask[i] & ( (force_mask[i] & force_val[i])
                                | (~force_mask[i] & keep_mask[i] & old_word)
                                | (~force_mask[i] & ~keep_mask[i] & data_in)));
      rd_word = (rd_word & ~force_mask[i]) | (force_mask[i] & force_val[i]);
    end
  end

  // Array and shadow-array update, including coupling-fault inversion of victim cells.
  always_comb begin
    mem_d    = mem_q;
    gold_d   = gold_q;
    fire     = '0;
    cfin_any = 1'b0;
    if (we) begin
      mem_d[data_addr]  = wr_word;
      gold_d[data_addr] = data_in;
      // Victim never equals the written address, so these inversions cannot clash with it.
      for (int i = 0; i < NUM_FAULTS; i++) begin
        fire                 = cfin_mask[i] & flip;
        mem_d[victim_addr[i]] = mem_d[victim_addr[i]] ^ fire;
        cfin_any             = cfin_any | (|fire);
      end
    end
  end

  // Registered read data, fault indication and handshake ready.
  always_comb begin
    data_out_d  = data_out_q;
    fault_hit_d = 1'b0;
    if (we) begin
      fault_hit_d = (wr_word != data_in) || cfin_any;
    end else begin
      data_out_d  = rd_word;
      fault_hit_d = (rd_word != gold_q[data_addr]);
    end
    cfg_ready_d = !cfg_accept;
  end

  // State registers; reset clears the array and discards any in-flight access or config.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q       <= '{default: '0};
      gold_q      <= '{default: '0};
      data_out_q  <= '0;
      fault_hit_q <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      gold_q      <= gold_d;
      data_out_q  <= data_out_d;
      fault_hit_q <= fault_hit_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign data_out  = data_out_q;
  assign fault_hit = fault_hit_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_fault_sram.sv
// Bench for fault_sram: a behavioural memory/fault-table model predicts every cycle,
// a negedge compare process checks it, and literal checks pin the model on key scenarios.
module tb_fault_sram;
  import fault_sram_pkg::*;

  localparam int W  = DEF_WORD_WIDTH;
  localparam int A  = DEF_ADDR_WIDTH;
  localparam int N  = DEF_NUM_FAULTS;
  localparam int IW = idx_width(N);
  localparam int BW = idx_width(W);
  localparam int D  = 1 << A;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic [A-1:0]  data_addr = '0;
  logic [W-1:0]  data_in = '0;
  logic [W-1:0]  data_out;
  logic          fault_hit;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [IW-1:0] cfg_idx = '0;
  logic [2:0]    cfg_type = '0;
  logic [A-1:0]  cfg_addr = '0;
  logic [A-1:0]  cfg_aggr_addr = '0;
  logic [BW-1:0] cfg_bit = '0;

  fault_sram dut (
    .clk           (clk),
    .rst           (rst),
    .we            (we),
    .data_addr     (data_addr),
    .data_in       (data_in),
    .data_out      (data_out),
    .fault_hit     (fault_hit),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_idx       (cfg_idx),
    .cfg_type      (cfg_type),
    .cfg_addr      (cfg_addr),
    .cfg_aggr_addr (cfg_aggr_addr),
    .cfg_bit       (cfg_bit)
  );

  always #(CLK_PERIOD / 2) clk = ~clk;

  // Model state
  logic [W-1:0] m_mem  [D];
  logic [W-1:0] m_gold [D];
  int           t_type [N];
  int           t_addr [N];
  int           t_aggr [N];
  int           t_bit  [N];
  logic [W-1:0] exp_dout = '0, nxt_dout;
  logic         exp_hit = 1'b0, nxt_hit;
  logic         exp_ready = 1'b0, nxt_ready;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the effect of the current inputs at the next rising edge.
  task automatic model_step();
    logic [W-1:0] old, nw, r;
    bit fired;
    int a;
    a = int'(data_addr);
    if (!rst) begin
      for (int k = 0; k < D; k++) begin
        m_mem[k]  = '0;
        m_gold[k] = '0;
      end
      for (int i = 0; i < N; i++) begin
        t_type[i] = 0; t_addr[i] = 0; t_aggr[i] = 0; t_bit[i] = 0;
      end
      nxt_dout = '0; nxt_hit = 1'b0; nxt_ready = 1'b0;
      return;
    end
    old      = m_mem[a];
    nxt_dout = exp_dout;
    if (we) begin
      nw = data_in;
      for (int b = 0; b < W; b++) begin
        for (int i = 0; i < N; i++) begin
          if (t_addr[i] == a && t_bit[i] == b && t_type[i] >= 1 && t_type[i] <= 4) begin
            case (t_type[i])
              1: nw[b] = 1'b0;
              2: nw[b] = 1'b1;
              3: if (!old[b]) nw[b] = 1'b0;
              default: if (old[b]) nw[b] = 1'b1;
            endcase
            break;
          end
        end
      end
      fired = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (t_type[i] == 5 && t_aggr[i] == a && t_aggr[i] != t_addr[i] &&
            nw[t_bit[i]] != old[t_bit[i]]) begin
          m_mem[t_addr[i]][t_bit[i]] = ~m_mem[t_addr[i]][t_bit[i]];
          fired = 1'b1;
        end
      end
      m_mem[a]  = nw;
      m_gold[a] = data_in;
      nxt_hit   = (nw != data_in) || fired;
    end else begin
      r = old;
      for (int b = 0; b < W; b++) begin
        for (int i = 0; i < N; i++) begin
          if (t_addr[i] == a && t_bit[i] == b && (t_type[i] == 1 || t_type[i] == 2)) begin
            r[b] = (t_type[i] == 2);
            break;
          end
        end
      end
      nxt_dout = r;
      nxt_hit  = (r != m_gold[a]);
    end
    if (cfg_valid && exp_ready) begin
      t_type[cfg_idx] = int'(cfg_type);
      t_addr[cfg_idx] = int'(cfg_addr);
      t_aggr[cfg_idx] = int'(cfg_aggr_addr);
      t_bit[cfg_idx]  = int'(cfg_bit);
      nxt_ready = 1'b0;
    end else begin
      nxt_ready = 1'b1;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    exp_dout  = nxt_dout;
    exp_hit   = nxt_hit;
    exp_ready = nxt_ready;
    #1;
  endtask

  task automatic wr(input int a, input int d);
    we = 1'b1; data_addr = A'(a); data_in = W'(d);
    cyc();
    we = 1'b0;
  endtask

  task automatic rd(input int a);
    we = 1'b0; data_addr = A'(a);
    cyc();
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 4 && cfg_ready !== 1'b1; k++) rd(int'(data_addr));
    chk("cfg_ready_wait", cfg_ready, 1);
  endtask

  task automatic set_cfg(input int idx, input int typ, input int vaddr, input int aaddr, input int b);
    cfg_idx = IW'(idx); cfg_type = 3'(typ); cfg_addr = A'(vaddr);
    cfg_aggr_addr = A'(aaddr); cfg_bit = BW'(b);
  endtask

  task automatic cfg(input int idx, input int typ, input int vaddr, input int aaddr, input int b);
    wait_ready();
    set_cfg(idx, typ, vaddr, aaddr, b);
    cfg_valid = 1'b1;
    rd(int'(data_addr));
    cfg_valid = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("data_out", data_out, exp_dout);
        chk("fault_hit", fault_hit, exp_hit);
        chk("cfg_ready", cfg_ready, exp_ready);
      end
    end
  end

  initial begin
    bit fail_seen;
    int fail_addr;

    // Reset
    rst = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("reset_dout", data_out, 0);
    chk("reset_hit", fault_hit, 0);
    chk("reset_ready", cfg_ready, 0);
    rst = 1'b1;
    rd(0);
    chk("ready_after_release", cfg_ready, 1);

    // Fault-free write/read
    wr(8'h10, 4'hA);
    chk("nofault_wr_hit", fault_hit, 0);
    rd(8'h10);
    chk("nofault_rd_dout", data_out, 4'hA);
    chk("nofault_rd_hit", fault_hit, 0);

    // Stuck-at-1
    cfg(0, 2, 8'h20, 0, 2);
    wr(8'h20, 4'h0);
    chk("sa1_wr_hit", fault_hit, 1);
    rd(8'h20);
    chk("sa1_rd_dout", data_out, 4'h4);
    chk("sa1_rd_hit", fault_hit, 1);

    // Transition faults
    cfg(1, 3, 8'h05, 0, 0);
    wr(8'h05, 4'h0);
    wr(8'h05, 4'hF);
    chk("tfup_wr_hit", fault_hit, 1);
    rd(8'h05);
    chk("tfup_rd_dout", data_out, 4'hE);
    cfg(3, 4, 8'h06, 0, 0);
    wr(8'h06, 4'hF);
    wr(8'h06, 4'h0);
    rd(8'h06);
    chk("tfdn_rd_dout", data_out, 4'h1);

    // Coupling fault: aggressor 0x01 -> victim 0x02 bit 3
    cfg(2, 5, 8'h02, 8'h01, 3);
    wr(8'h01, 4'h0);
    wr(8'h02, 4'h0);
    wr(8'h01, 4'h8);
    chk("cfin_trigger_hit", fault_hit, 1);
    rd(8'h02);
    chk("cfin_victim_dout", data_out, 4'h8);
    wr(8'h01, 4'h8);
    chk("cfin_no_change_hit", fault_hit, 0);
    rd(8'h02);
    chk("cfin_victim_stable", data_out, 4'h8);

    // Priority: SA0 in slot 0 beats SA1 in slot 1 on the same cell
    cfg(0, 1, 8'h30, 0, 1);
    cfg(1, 2, 8'h30, 0, 1);
    wr(8'h30, 4'hF);
    rd(8'h30);
    chk("priority_dout", data_out, 4'hD);

    // Config accepted in the same cycle as a write
    wait_ready();
    set_cfg(3, 2, 8'h40, 0, 0);
    cfg_valid = 1'b1;
    wr(8'h40, 4'h0);
    cfg_valid = 1'b0;
    chk("coincident_wr_hit", fault_hit, 0);
    chk("coincident_ready_low", cfg_ready, 0);
    rd(8'h40);
    chk("coincident_ready_back", cfg_ready, 1);
    chk("coincident_new_entry_dout", data_out, 4'h1);

    // Reserved code 7 behaves as NONE
    cfg(3, 7, 8'h40, 0, 0);
    rd(8'h40);
    chk("code7_dout", data_out, 4'h0);
    chk("code7_hit", fault_hit, 0);

    // Simple march: SA0 at 0x7F bit 0
    cfg(0, 1, 8'h7F, 0, 0);
    cfg(1, 0, 0, 0, 0);
    cfg(2, 0, 0, 0, 0);
    for (int a = 0; a < D; a++) wr(a, 4'hF);
    fail_seen = 1'b0;
    fail_addr = -1;
    for (int a = 0; a < D; a++) begin
      rd(a);
      if (data_out !== 4'hF && !fail_seen) begin
        fail_seen = 1'b1;
        fail_addr = a;
      end
    end
    chk("march_fail", fail_seen, 1);
    chk("march_fail_addr", fail_addr, 32'h7F);

    // Reset in the middle of a write and a config handshake
    wait_ready();
    set_cfg(0, 2, 8'h7F, 0, 1);
    cfg_valid = 1'b1;
    we = 1'b1; data_addr = 8'h7F; data_in = 4'hF;
    rst = 1'b0;
    cyc();
    rst = 1'b1; cfg_valid = 1'b0; we = 1'b0;
    chk("midrst_dout", data_out, 0);
    chk("midrst_ready", cfg_ready, 0);
    rd(8'h7F);
    chk("midrst_rd_dout", data_out, 0);
    chk("midrst_rd_hit", fault_hit, 0);
    wr(8'h7F, 4'hF);
    rd(8'h7F);
    chk("midrst_table_cleared", data_out, 4'hF);

    // Mixed traffic on a small address window, checked by the model every cycle
    for (int k = 0; k < 300; k++) begin
      we        = 1'($urandom_range(1, 0));
      data_addr = A'($urandom_range(7, 0));
      data_in   = W'($urandom_range(15, 0));
      cfg_valid = ($urandom_range(3, 0) == 0);
      set_cfg($urandom_range(N - 1, 0), $urandom_range(7, 0), $urandom_range(7, 0),
              $urandom_range(7, 0), $urandom_range(W - 1, 0));
      cyc();
    end
    cfg_valid = 1'b0;
    we = 1'b0;
    rd(0);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fault_sram.md
FAULT_SRAM -- requirements
Module: fault_sram

Interface
REQ-001 SHALL take parameters: SRAM_WORD_WIDTH, default `SRAM_WORD_WIDTH (4), word width; SRAM_ADDR_WIDTH, default `SRAM_ADDR_WIDTH (8), address width; NUM_FAULTS, default 4, fault-table entries.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on posedge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 we  in  1  write enable from BIST; 0 = read.
REQ-005 data_addr  in  SRAM_ADDR_WIDTH  access address.
REQ-006 data_in  in  SRAM_WORD_WIDTH  write data.
REQ-007 data_out  out  SRAM_WORD_WIDTH  registered read data.
REQ-008 fault_hit  out  1  registered pulse: previous access was altered by a fault.
REQ-009 cfg_valid / cfg_ready  in / out  1 / 1  fault-table programming handshake.
REQ-010 cfg_idx  in  log2(NUM_FAULTS)  entry selected.
REQ-011 cfg_type  in  3  fault type code.
REQ-012 cfg_addr / cfg_aggr_addr  in  SRAM_ADDR_WIDTH each  victim / aggressor address.
REQ-013 cfg_bit  in  log2(SRAM_WORD_WIDTH)  victim (and aggressor) bit index.

Function
REQ-014 Array SHALL be 2^SRAM_ADDR_WIDTH x SRAM_WORD_WIDTH registers; memory responder to BIST controllers (access initiators).
REQ-015 Fault types SHALL be: NONE=0, SA0=1, SA1=2, TF_UP=3 (bit cannot go 0->1), TF_DN=4 (bit cannot go 1->0), CFIN=5 (aggressor bit transition inverts victim bit); codes 6-7 treated as NONE.
REQ-016 Write (we=1): stored word at data_addr SHALL equal data_in with, per bit, first matching entry (lowest index wins) applied: SA0 -> 0, SA1 -> 1, TF_UP -> stays 0 if old 0, TF_DN -> stays 1 if old 1.
REQ-017 CFIN: when write at cfg_aggr_addr changes stored bit cfg_bit (old != new after REQ-016), victim bit cfg_bit at cfg_addr SHALL invert in the same cycle; ignored if cfg_addr == cfg_aggr_addr.
REQ-018 Read (we=0): data_out SHALL update next cycle (latency 1) to mem[data_addr] with SA0/SA1 entries for that address forced on output; during write cycles data_out holds.
REQ-019 fault_hit SHALL be 1 for exactly the cycle after an access whose stored or returned word differed from fault-free value, or that triggered a CFIN inversion; else 0.
REQ-020 Config accepted when cfg_valid && cfg_ready; entry cfg_idx overwritten; cfg_ready SHALL drop for one cycle after each acceptance, then return to 1.
REQ-021 Acceptance coincident with an access: access SHALL use the old table; new entry effective next cycle.
REQ-022 Address SHALL wrap naturally (no out-of-range); victim bit index beyond width unreachable by width.

Reset
REQ-023 While rst=0 at posedge: all entries = NONE, entire array = 0, data_out = 0, fault_hit = 0, cfg_ready = 0; first cycle after release cfg_ready = 1.
REQ-024 Reset mid-access or mid-handshake SHALL discard the access and any pending config.

Structure
REQ-025 Fault type codes and NUM_FAULTS default SHALL live in shared parameters.vh alongside width/CLK_PERIOD constants.
REQ-026 One sub-module fault_entry SHALL hold one table slot and emit per-address force/keep/invert masks; fault_sram instantiates NUM_FAULTS copies and reduces by priority.

Verification
REQ-027 No faults: write 0xA to 0x10, read 0x10 -> data_out=0xA one cycle later, fault_hit=0.
REQ-028 Entry0 SA1 addr 0x20 bit 2: write 0x0 to 0x20, read -> 0x4, fault_hit=1 after write and read.
REQ-029 Entry1 TF_UP addr 0x05 bit 0: write 0x0 then 0xF, read -> 0xE; entry TF_DN analog -> 0x1.
REQ-030 Entry2 CFIN aggr 0x01 victim 0x02 bit 3: write 0x0 to both, write 0x8 to 0x01, read 0x02 -> 0x8; rewrite 0x8 to 0x01 -> no inversion.
REQ-031 Conflict: entries 0 (SA0) and 1 (SA1) same bit -> SA0 wins; config accepted same cycle as write -> write unaffected; cfg_ready low exactly one cycle.
REQ-032 Run BL/CH/MC/MA BIST against this block with one SA0 at 0x7F -> fail asserted, fail_addr=0x7F; rst=0 mid-run -> table cleared, data_out=0.
